// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and types for the FIFO-to-stream reader.
package fifo_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_BURST_LEN = 4;

    typedef logic [15:0] count16_t;

    // Beat counter width; a single-word burst still needs one bit to exist.
    function automatic int beat_width(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus output stream, bundled for the reader and its environment.
interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_rd_en;

    // Stream handshake: a word moves on every clock edge where m_valid and
    // m_ready are both high. Once m_valid rises it stays high, with m_data and
    // m_last unchanged, until that transfer happens; m_valid never waits on m_ready.
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );

endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry in-order buffer between the FIFO read data and the output stream.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       occ_q;
    logic             pop_ok;
    logic             push_ok;

    // The issuer never oversubscribes; these guards only keep the pointers sane.
    assign pop_ok  = pop & (occ_q != 2'd0);
    assign push_ok = push & ((occ_q != 2'd2) | pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            occ_q <= occ_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign occ       = occ_q;
    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a synchronous FIFO and presents its words as a valid/ready stream
// with burst framing (m_last) and a running transfer count.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    fifo_stream_reader_if.master        bus,
    output count16_t                    words_sent
);

    localparam int                BEAT_W    = beat_width(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic              run_q;
    logic              inflight_q;
    logic [BEAT_W-1:0] beat_q;
    count16_t          sent_q;
    logic [1:0]        occ;
    logic [2:0]        pending;
    logic              xfer;
    logic              room;
    logic              rd_en;
    logic [WIDTH-1:0]  head_data;

    assign xfer    = bus.m_valid & bus.m_ready;
    assign pending = {1'b0, occ} + {2'b0, inflight_q};

    // A read is safe if the word it returns will find a free slot, counting
    // the word already in flight and any slot freed by this cycle's transfer.
    assign room  = (pending < 3'd2) | ((pending == 3'd2) & xfer);
    // run_q holds reads off until the first edge after reset is released.
    assign rd_en = run_q & enable & ~bus.fifo_empty & room;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b0;
            inflight_q <= 1'b0;
            beat_q     <= '0;
            sent_q     <= '0;
        end else begin
            run_q      <= 1'b1;
            inflight_q <= rd_en;
            if (xfer) begin
                beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
                sent_q <= sent_q + 16'd1;
            end
        end
    end

    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (bus.fifo_data),
        .pop       (xfer),
        .occ       (occ),
        .head_data (head_data)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (occ != 2'd0);
    assign bus.m_data     = head_data;
    assign bus.m_last     = bus.m_valid & (beat_q == LAST_BEAT);
    assign words_sent     = sent_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model, stream scoreboard, table and scenario tests.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    localparam int W  = 8;
    localparam int BL = 4;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    logic     enable = 1'b0;
    count16_t words_sent;

    fifo_stream_reader_if #(.WIDTH(W)) bus ();

    fifo_stream_reader #(.WIDTH(W), .BURST_LEN(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bus        (bus.master),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Synchronous FIFO model: words pushed by the driver, popped on rd_en.
    logic [W-1:0] src_mem [1024];
    int           wr_idx = 0;
    int           rd_idx = 0;

    assign bus.fifo_empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (bus.fifo_rd_en && (rd_idx != wr_idx)) begin
            bus.fifo_data <= src_mem[rd_idx];
            rd_idx        <= rd_idx + 1;
        end
    end

    task automatic push_word(input logic [W-1:0] w);
        src_mem[wr_idx] = w;
        wr_idx++;
    endtask

    // Scoreboard: words read from the FIFO must leave in order, none lost or duplicated.
    logic [W-1:0] exp_q[$];
    int           beat_m = 0;
    int           n_xfer = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         prev_last = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            beat_m     = 0;
            prev_stall = 1'b0;
            check("reset_m_valid", bus.m_valid, 0);
            check("reset_m_last", bus.m_last, 0);
            check("reset_m_data", bus.m_data, 0);
            check("reset_rd_en", bus.fifo_rd_en, 0);
        end else begin
            if (bus.fifo_rd_en) begin
                check("rd_while_empty", bus.fifo_empty, 0);
                check("rd_without_enable", enable, 1);
            end
            check("buffered_le2", exp_q.size() <= 2, 1);
            if (prev_stall) begin
                check("stall_valid", bus.m_valid, 1);
                check("stall_data", bus.m_data, prev_data);
                check("stall_last", bus.m_last, prev_last);
            end
            if (bus.m_valid && bus.m_ready) begin
                check("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("m_data_order", bus.m_data, exp_q.pop_front());
                    check("m_last_beat", bus.m_last, beat_m == BL - 1);
                end
                beat_m = (beat_m == BL - 1) ? 0 : beat_m + 1;
                n_xfer++;
            end
            if (bus.fifo_rd_en && !bus.fifo_empty) begin
                exp_q.push_back(src_mem[rd_idx]);
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
        end
    end

    typedef struct packed {
        logic         en;
        logic         rdy;
        logic         exp_rd;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        logic         exp_last;
    } vec_t;

    vec_t vecs [11];
    int   sent_base = 0;
    int   xfer_base = 0;

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (!(exp_q.size() == 0 && bus.fifo_empty && !bus.m_valid) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("drain_done", exp_q.size() == 0 && bus.fifo_empty && !bus.m_valid, 1);
    endtask

    task automatic check_sent(input string name);
        check(name, words_sent, 16'(sent_base + (n_xfer - xfer_base)));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int xb;
        int reads;
        int pushed;

        // Preloaded 0x01..0x08, ready high: latency 2, then one word per cycle.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h06, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h08, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

        bus.m_ready   = 1'b1;
        bus.fifo_data = '0;
        enable        = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(W'(i));
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_words_sent", words_sent, 0);
        check("rst_rd_en_fifo_full", bus.fifo_rd_en, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rd_before_first_edge", bus.fifo_rd_en, 0);

        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            enable      = vecs[i].en;
            bus.m_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d_rd_en", i), bus.fifo_rd_en, vecs[i].exp_rd);
            check($sformatf("vec%0d_m_valid", i), bus.m_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) check($sformatf("vec%0d_m_data", i), bus.m_data, vecs[i].exp_data);
            check($sformatf("vec%0d_m_last", i), bus.m_last, vecs[i].exp_last);
        end
        check("burst_words_sent", words_sent, 16'd8);

        // Downstream stall mid-stream: buffer fills to two and holds.
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) push_word(W'(8'h10 + i));
        repeat (4) @(posedge clk);
        #1 bus.m_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_buffered", exp_q.size(), 2);
        check("stall_m_valid", bus.m_valid, 1);
        @(posedge clk);
        #1 bus.m_ready = 1'b1;
        wait_idle(50);
        check_sent("stall_words_sent");

        // Enable dropped right after three reads.
        @(posedge clk);
        #1 enable = 1'b0;
        for (int i = 0; i < 6; i++) push_word(W'(8'h40 + i));
        xb = n_xfer;
        @(posedge clk);
        #1 enable = 1'b1;
        reads = 0;
        for (int i = 0; i < 20 && reads < 3; i++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) reads++;
        end
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (10) @(negedge clk);
        check("enable_drop_words", n_xfer - xb, 3);
        check("enable_drop_left", wr_idx - rd_idx, 3);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_idle(50);
        check_sent("enable_words_sent");

        // Random ready, enable and FIFO fill over 200 words.
        xb = n_xfer;
        pushed = 0;
        for (int cyc = 0; cyc < 5000 && (n_xfer - xb) < 200; cyc++) begin
            @(posedge clk);
            #1;
            if (pushed < 200 && $urandom_range(0, 3) != 0) begin
                push_word(W'($urandom));
                pushed++;
            end
            bus.m_ready = 1'($urandom_range(0, 1));
            enable      = ($urandom_range(0, 7) != 0);
        end
        check("random_word_count", n_xfer - xb, 200);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        enable      = 1'b1;
        wait_idle(50);
        check_sent("random_words_sent");

        // Reset with two words buffered: they are discarded.
        @(posedge clk);
        #1 bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(W'(8'h50 + i));
        repeat (5) @(negedge clk);
        check("pre_reset_buffered", exp_q.size(), 2);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_rst_m_valid", bus.m_valid, 0);
        check("async_rst_words_sent", words_sent, 0);
        check("async_rst_rd_en", bus.fifo_rd_en, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        sent_base   = 0;
        xfer_base   = n_xfer;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 20 && !bus.m_valid; i++) @(negedge clk);
        check("first_after_reset", bus.m_data, 8'h52);
        wait_idle(50);
        check_sent("reset_words_sent");

        // words_sent wrap: start from 0xFFFE and send three words.
        @(posedge clk);
        #1 force dut.sent_q = 16'hFFFE;
        #1 release dut.sent_q;
        sent_base = 16'hFFFE;
        xfer_base = n_xfer;
        @(negedge clk);
        check("forced_words_sent", words_sent, 16'hFFFE);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) push_word(W'(8'h70 + i));
        for (int i = 0; i < 20 && !(bus.m_valid && bus.m_ready); i++) @(negedge clk);
        @(negedge clk);
        check("wrap_seq0", words_sent, 16'hFFFF);
        @(negedge clk);
        check("wrap_seq1", words_sent, 16'h0000);
        @(negedge clk);
        check("wrap_seq2", words_sent, 16'h0001);
        wait_idle(20);
        check_sent("wrap_words_sent");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter BURST_LEN, default 4, words per burst; legal range 1..256.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  when high, the block may issue new FIFO reads.
REQ-006 fifo_empty  input  1  empty flag from the synchronous FIFO.
REQ-007 fifo_data  input  WIDTH  FIFO read data, valid one cycle after fifo_rd_en.
REQ-008 fifo_rd_en  output  1  FIFO read strobe, one word per asserted cycle.
REQ-009 m_valid  output  WIDTH-independent 1  output stream word valid.
REQ-010 m_ready  input  1  downstream accepts the word when high with m_valid.
REQ-011 m_data  output  WIDTH  output stream word.
REQ-012 m_last  output  1  marks the final word of each BURST_LEN-word burst.
REQ-013 words_sent  output  16  count of completed output transfers.

Function
REQ-014 fifo_rd_en SHALL be combinational: enable & !fifo_empty & (occ+inflight < 2, or occ+inflight == 2 with a transfer this cycle).
- occ: words held in the 2-entry output buffer (0..2).
- inflight: 1 if fifo_rd_en was high last cycle, else 0.
REQ-015 fifo_rd_en SHALL never be high while fifo_empty is high.
REQ-016 fifo_data SHALL be captured into the buffer on the posedge ending the cycle after fifo_rd_en.
REQ-017 The output buffer SHALL never exceed 2 entries and SHALL never drop or duplicate a word.
REQ-018 A transfer SHALL occur when m_valid & m_ready; words SHALL leave in FIFO read order.
REQ-019 m_valid SHALL be high whenever occ > 0.
REQ-020 While m_valid & !m_ready, m_data, m_last and m_valid SHALL hold stable.
REQ-021 Latency: fifo_empty falls in cycle 0 with enable high and the buffer empty -> fifo_rd_en high in cycle 0 -> m_valid high in cycle 2.
REQ-022 With m_ready held high and the FIFO non-empty, throughput SHALL be one word per cycle after the initial 2-cycle latency.
REQ-023 The beat counter SHALL count 0..BURST_LEN-1, advance on each transfer and wrap to 0 after BURST_LEN-1.
REQ-024 m_last SHALL equal (beat counter == BURST_LEN-1) & m_valid; with BURST_LEN=1, m_last SHALL be high on every word.
REQ-025 words_sent SHALL increment by 1 per transfer and wrap from 0xFFFF to 0x0000.
REQ-026 When enable falls, new reads SHALL stop the same cycle; in-flight and buffered words SHALL still drain.
REQ-027 When the FIFO empties mid-burst, the beat count SHALL be held and the burst resumes on later words.

Reset
REQ-028 rst low SHALL asynchronously clear occ, inflight, beat counter and words_sent.
- Outputs during reset: m_valid=0, m_last=0, m_data=0, fifo_rd_en=0.
REQ-029 Reset asserted mid-operation SHALL discard buffered and in-flight words; no word SHALL appear after release unless freshly read.
REQ-030 The first fifo_rd_en SHALL occur no earlier than the first posedge after rst deasserts.

Structure
REQ-031 A shared package fifo_pkg SHALL hold the default WIDTH, the BURST_LEN default and a 16-bit counter typedef.
REQ-032 The 2-entry buffer SHALL be a sub-module stream_skid_buf with push/pop/occ ports; the top holds the read issue logic and counters.

Verification
REQ-033 FIFO preloaded with 0x01..0x08, m_ready=1, enable=1 -> m_data 0x01..0x08 on consecutive cycles; m_last on 0x04 and 0x08; words_sent=8.
REQ-034 m_ready low for 5 cycles mid-stream -> m_data held; at most 2 words buffered; no loss; order preserved.
REQ-035 Random m_ready (50%) over 200 words -> output sequence equals input sequence; fifo_rd_en never high with fifo_empty.
REQ-036 enable dropped after 3 reads -> exactly 3 words emitted; no further fifo_rd_en until enable returns.
REQ-037 rst pulsed low with 2 words buffered -> m_valid=0 immediately; words_sent=0; the next output is the next FIFO word.
REQ-038 Force words_sent to 0xFFFE, send 3 words -> words_sent sequence 0xFFFF, 0x0000, 0x0001.
